event_uart_tx: RTL

EVENT_UART_TX -- requirements
Module: event_uart_tx

---
 rtl/event_uart_tx.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/event_uart_tx.sv
// Event/score packet transmitter: a small event FIFO and a score-request flag feed a
// 3-byte-packet 8N1 serialiser. Score packets take priority over queued events.
module event_uart_tx #(
  parameter int unsigned BIT_TICKS  = 434,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        CLOCK50M,
  input  logic        RESET_N,
  input  logic        ev_valid,
  input  logic [17:0] ev_data,
  output logic        ev_ready,
  input  logic [10:0] score,
  input  logic        score_req,
  output logic        uart_txd,
  output logic        busy,
  output logic        overflow,
  output logic [2:0]  fifo_level
);

  localparam int unsigned TickW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [TickW-1:0] LastTick  = TickW'(BIT_TICKS - 1);
  localparam logic [PtrW-1:0]  LastPtr   = PtrW'(FIFO_DEPTH - 1);
  localparam logic [2:0]       FullLevel = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e             state_q, state_d;
  logic [TickW-1:0]   tick_q, tick_d;
  logic [2:0]         bit_q, bit_d;
  logic [1:0]         byte_q, byte_d;
  logic [23:0]        pkt_q, pkt_d;
  logic               txd_q, txd_d;
  logic               pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic [2:0]         count_q, count_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [17:0]        mem_q [FIFO_DEPTH];

  logic        full, push, pop, launch, tick_end;
  logic [17:0] head;
  logic [23:0] ev_pkt, sc_pkt;
  logic [7:0]  cur_byte;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count_q == FullLevel);
  assign push     = ev_valid && !full;
  assign launch   = (state_q == StIdle) && (pend_q || (count_q != 3'd0));
  // A launch serves the score request first; only otherwise does it consume the FIFO head.
  assign pop      = launch && !pend_q;
  assign tick_end = (tick_q == LastTick);
  assign head     = mem_q[rd_ptr_q];

  // head = {ts[9:0], keys[7:0]}
  assign ev_pkt = {2'b10, head[17:12], 2'b00, head[11:8], head[7:6], 2'b00, head[5:0]};
  assign sc_pkt = {2'b11, 3'b000, score[10:8], 2'b00, score[7:2], 2'b00, score[1:0], 4'b0000};

  // FIFO bookkeeping, score-pending flag and sticky overflow.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !pop) begin
      count_d = count_q + 3'd1;
    end else if (!push && pop) begin
      count_d = count_q - 3'd1;
    end
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    // A request in the launch cycle of a score packet re-arms the flag for one more packet.
    pend_d = score_req || (pend_q && !launch);
    ovf_d  = ovf_q || (ev_valid && full);
  end

  // Bit/byte sequencer: IDLE -> (START -> DATA x8 -> STOP) x3 -> IDLE.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    pkt_d   = pkt_q;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          state_d = StStart;
          tick_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
          pkt_d   = pend_q ? sc_pkt : ev_pkt;
        end
      end
      StStart: begin
        if (tick_end) begin
          state_d = StData;
          tick_d  = '0;
          bit_d   = '0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StData: begin
        if (tick_end) begin
          tick_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StStop: begin
        if (tick_end) begin
          tick_d = '0;
          if (byte_q == 2'd2) begin
            state_d = StIdle;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = StStart;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level is decoded from the next state so the register output lines up with it.
  always_comb begin
    cur_byte = pkt_d[7:0];
    txd_d    = 1'b1;
    unique case (byte_d)
      2'd0:    cur_byte = pkt_d[23:16];
      2'd1:    cur_byte = pkt_d[15:8];
      default: cur_byte = pkt_d[7:0];
    endcase
    unique case (state_d)
      StStart: txd_d = 1'b0;
      StData:  txd_d = cur_byte[bit_d];
      default: txd_d = 1'b1;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLOCK50M) begin
    if (!RESET_N) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      pkt_q    <= '0;
      txd_q    <= 1'b1;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      pkt_q    <= pkt_d;
      txd_q    <= txd_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are meaningless while the count is zero, so no reset.
  always_ff @(posedge CLOCK50M) begin
    if (push) mem_q[wr_ptr_q] <= ev_data;
  end

  assign uart_txd   = txd_q;
  assign busy       = (state_q != StIdle) || launch;
  assign overflow   = ovf_q;
  assign fifo_level = count_q;
  assign ev_ready   = !full;

endmodule
